// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: default word width, word type and zero constant.
package alu_pkg;

    localparam int ALU_W = 8;

    typedef logic [ALU_W-1:0] alu_word_t;

    localparam alu_word_t ALU_ZERO = '0;

endpackage : alu_pkg

// File: rtl/full_adder_1bit.sv
// Single-bit full adder; one stage of the subtractor's ripple-carry chain.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_1bit

// File: rtl/subtractor_8bit.sv
// Registered unsigned subtractor: result = reg1 - reg2 computed as reg1 + ~reg2 + 1
// on a ripple-carry chain, registered with the carry-out (1 = no borrow).
// Optional macro SUBTRACTOR_ABS_DIFF_EN: on borrow the registered result is the
// two's-complement negation of the raw difference, i.e. |reg1 - reg2|.
module subtractor_8bit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] reg1,
    input  logic [WIDTH-1:0] reg2,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] next_result;

    // Carry-in of the LSB is the "+1" of the two's-complement subtrahend.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_1bit u_fa (
            .a    (reg1[i]),
            .b    (~reg2[i]),
            .cin  (carry[i]),
            .s    (diff[i]),
            .cout (carry[i+1])
        );
    end

    // Select the value to register: raw difference, or its magnitude on borrow.
    always_comb begin
        next_result = diff;
`ifdef SUBTRACTOR_ABS_DIFF_EN
        if (!carry[WIDTH]) begin
            next_result = ~diff + WIDTH'(1);
        end
`endif
    end

    // Output register; asynchronous active-low reset clears result and carry-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            cout   <= 1'b0;
        end else begin
            result <= next_result;
            cout   <= carry[WIDTH];
        end
    end

endmodule : subtractor_8bit

// File: tb/tb_subtractor_8bit.sv
// Directed and random checks of subtractor_8bit (1-cycle latency, async reset).
// Honours SUBTRACTOR_ABS_DIFF_EN for the expected results.
module tb_subtractor_8bit;

    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] reg1;
    logic [7:0] reg2;
    logic [7:0] result;
    logic       cout;

    int unsigned compared;
    int unsigned mismatched;

    subtractor_8bit #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .reg1   (reg1),
        .reg2   (reg2),
        .result (result),
        .cout   (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {c, d} = {0, a} + {0, ~b} + 1; magnitude on borrow when ABS enabled.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        r = {1'b0, a} + {1'b0, ~b} + 9'd1;
`ifdef SUBTRACTOR_ABS_DIFF_EN
        if (!r[8]) r[7:0] = b - a;
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {cout, result};
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed result=%0d cout=%0d, expected result=%0d cout=%0d",
                   tag, obs[7:0], obs[8], exp[7:0], exp[8]);
        end
    endtask

    // Hand-computed directed expectations (raw / ABS variants).
`ifdef SUBTRACTOR_ABS_DIFF_EN
    localparam logic [8:0] EXP_10_20 = {1'b0, 8'd10};
    localparam logic [8:0] EXP_5_10  = {1'b0, 8'd5};
    localparam logic [8:0] EXP_0_255 = {1'b0, 8'd255};
`else
    localparam logic [8:0] EXP_10_20 = {1'b0, 8'd246};
    localparam logic [8:0] EXP_5_10  = {1'b0, 8'd251};
    localparam logic [8:0] EXP_0_255 = {1'b0, 8'd1};
`endif

    // Apply one operand pair at a falling edge, check one rising edge later.
    task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [8:0] exp);
        @(negedge clk);
        reg1 = a;
        reg2 = b;
        @(negedge clk);
        check(tag, exp);
    endtask

    initial begin : stim
        logic [8:0] exp_q;
        compared   = 0;
        mismatched = 0;
        rst_n = 1'b1;
        reg1  = 8'd30;
        reg2  = 8'd10;
        #1 rst_n = 1'b0;
        #1 check("reset_initial", {1'b0, ALU_ZERO});
        @(negedge clk);
        check("reset_hold", 9'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_first_edge", {1'b1, 8'd20});

        // No borrow and borrow wrap
        step("no_borrow_30_10", 8'd30, 8'd10, {1'b1, 8'd20});
        step("borrow_10_20",    8'd10, 8'd20, EXP_10_20);
        step("borrow_5_10",     8'd5,  8'd10, EXP_5_10);

        // Asynchronous reset mid-run, away from any clock edge
        step("pre_reset_30_10", 8'd30, 8'd10, {1'b1, 8'd20});
        #1 rst_n = 1'b0;
        #1 check("async_reset_midrun", 9'd0);
        @(negedge clk);
        check("reset_held_low", 9'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_20_1", {1'b1, 8'd20});

        // Back-to-back operands on consecutive edges
        @(negedge clk);
        reg1 = 8'd30; reg2 = 8'd10;
        @(negedge clk);
        check("b2b_0", {1'b1, 8'd20});
        reg1 = 8'd5;  reg2 = 8'd10;
        @(negedge clk);
        check("b2b_1", EXP_5_10);
        reg1 = 8'd30; reg2 = 8'd10;
        @(negedge clk);
        check("b2b_2", {1'b1, 8'd20});

        // Boundaries
        step("bound_0_0",     8'd0,   8'd0,   {1'b1, 8'd0});
        step("bound_255_255", 8'd255, 8'd255, {1'b1, 8'd0});
        step("bound_0_255",   8'd0,   8'd255, EXP_0_255);
        step("bound_255_0",   8'd255, 8'd0,   {1'b1, 8'd255});
        step("reg2_zero",     8'd77,  8'd0,   {1'b1, 8'd77});

        // Random pairs, pipelined: check the previous pair while applying the next
        @(negedge clk);
        reg1  = 8'($urandom_range(0, 255));
        reg2  = 8'($urandom_range(0, 255));
        exp_q = model(reg1, reg2);
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            check("random", exp_q);
            reg1  = 8'($urandom_range(0, 255));
            reg2  = 8'($urandom_range(0, 255));
            exp_q = model(reg1, reg2);
        end
        @(negedge clk);
        check("random_last", exp_q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_subtractor_8bit
